line_buf_ctrl: RTL and testbench
================================

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the line buffer word-address width.
REQ-002 SHALL have input clk, 1 bit, the rising-edge clock.
REQ-003 SHALL have input reset, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have input fs_in, 1 bit, a frame-start pulse from the byte-to-pixel stage.
REQ-005 SHALL have input wr_valid, 1 bit, meaning a 32-bit pixel word is available for the line buffer.
REQ-006 SHALL have input wr_last, 1 bit, qualified by wr_valid, marking the last word of a line.
REQ-007 SHALL have input tready, 1 bit, the AXI4-Stream sink ready.
REQ-008 SHALL have output we, 1 bit, the line-buffer write enable.
REQ-009 SHALL have output wr_sel, 1 bit, the buffer being written (0/1).
REQ-010 SHALL have output wr_addr, ADDR_W bits, the write word address.
REQ-011 SHALL have output rd_sel, 1 bit, the buffer being read.
REQ-012 SHALL have output rd_addr, ADDR_W bits, the read address; buffer read is combinational, so data is valid in the same cycle.
REQ-013 SHALL have outputs tvalid, tuser and tlast, 1 bit each, the AXI4-Stream sideband signals (tuser = start of frame, tlast = end of line).
REQ-014 SHALL have output ovf, 1 bit, a one-cycle pulse when a line is dropped.
REQ-015 SHALL have output full, 2 bits, the per-buffer FULL status.

Function
REQ-016 SHALL keep per-buffer state: full[b], len[b] (ADDR_W bits, word count) and sof[b].
REQ-017 SHALL set we = wr_valid && !full[wr_sel] && !drop, and the write SHALL be combinational from registered wr_sel and wr_addr.
REQ-018 SHALL, on an accepted write without wr_last, increment wr_addr modulo 2^ADDR_W.
REQ-019 SHALL, on an accepted write with wr_last, apply all of the following:
- set full[wr_sel]=1;
- set len[wr_sel]=wr_addr+1 (truncated to ADDR_W bits);
- set sof[wr_sel]=sof_pend and clear sof_pend;
- toggle wr_sel;
- clear wr_addr.
REQ-020 SHALL set sof_pend on fs_in; if fs_in coincides with a line-completing write, the new frame flag SHALL survive (set wins) and the completing line SHALL take the old sof_pend.
REQ-021 SHALL, on wr_valid while full[wr_sel]=1, enter drop mode: discard words up to and including wr_last, pulse ovf once on the first discarded word, and leave wr_sel and wr_addr unchanged.
REQ-022 SHALL clear drop mode on the wr_last of the dropped line; a dropped line SHALL NOT consume sof_pend.
REQ-023 SHALL implement a read FSM with states IDLE and STREAM.
REQ-024 SHALL, in IDLE, move to STREAM with rd_addr=0 on the next edge if full[rd_sel]=1.
REQ-025 SHALL, in STREAM, drive tvalid=1, tuser=sof[rd_sel] && rd_addr==0, and tlast=(rd_addr==len[rd_sel]-1).
REQ-026 SHALL increment rd_addr on tvalid&&tready; tvalid SHALL stay high and rd_addr SHALL hold while tready=0.
REQ-027 SHALL, on a handshake with tlast=1, clear full[rd_sel], toggle rd_sel and return to IDLE; tvalid SHALL be 0 for at least one cycle between lines.
REQ-028 SHALL apply both updates when a write completes into one buffer and a read releases the other in the same cycle.
REQ-029 SHALL never alias read and write buffers: a write SHALL only target a buffer with full=0, and a read SHALL only source a buffer with full=1.
REQ-030 SHALL drive tvalid, tuser and tlast to 0 in IDLE.

Reset
REQ-031 SHALL, while reset=0, asynchronously set the following:
- FSM=IDLE;
- wr_sel=rd_sel=0 and wr_addr=rd_addr=0;
- full=2'b00, len=0, sof=0, sof_pend=0, drop=0;
- we, tvalid, tuser, tlast and ovf all 0.
REQ-032 SHALL, on reset mid-line or mid-stream, discard partial content; the first line after release SHALL be written to buffer 0.

Verification
REQ-033 SHALL cover single line: fs_in, then 5 words 05,04,03,02,01 with wr_last on the 5th, tready=1 -> wr_addr 0..4 with we=1; one IDLE cycle, then tvalid for 5 cycles with rd_addr 0..4, tuser on addr 0, tlast on addr 4; full returns to 00.
REQ-034 SHALL cover backpressure: same line with tready toggling 1,0,1,0 -> rd_addr advances only on tready=1, all 5 words are transferred, and tlast occurs exactly once.
REQ-035 SHALL cover ping-pong: two 5-word lines back-to-back with tready=0 -> full=11 after the second line; the first line then streams from buffer 0 and the second from buffer 1, and tuser is set only on the first line.
REQ-036 SHALL cover overflow: a third line while full=11 -> ovf pulses once, we stays 0 for all 5 words, and the first two lines stream unchanged.
REQ-037 SHALL cover mid-stream reset: reset asserted at rd_addr=2 -> all outputs are 0 immediately, and the next line is written to buffer 0 from address 0.
REQ-038 SHALL cover simultaneous events: a line completing into buffer 1 on the same cycle that buffer 0's tlast handshakes -> full goes 01 to 10 and rd_sel=1, with streaming starting after one IDLE cycle.

Source files
------------

// File: rtl/line_buf_ctrl.sv
// Ping-pong line buffer controller: writes pixel words into one of two line
// buffers and streams completed lines out as AXI4-Stream sideband and addresses.
module line_buf_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_in,
  input  logic              wr_valid,
  input  logic              wr_last,
  input  logic              tready,
  output logic              we,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tvalid,
  output logic              tuser,
  output logic              tlast,
  output logic              ovf,
  output logic [1:0]        full
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                   r_state;
  logic [1:0]               r_full;
  logic [1:0][ADDR_W-1:0]   r_len;
  logic [1:0]               r_sof;
  logic                     r_sof_pend;
  logic                     r_drop;
  logic                     r_wr_sel;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic                     r_rd_sel;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic                     r_tvalid;
  logic                     r_tuser;
  logic                     r_tlast;

  logic                     w_wr_full;
  logic                     w_we;
  logic                     w_wr_done;
  logic                     w_ovf;
  logic                     w_rd_done;
  logic [ADDR_W-1:0]        w_len_m1;
  logic [ADDR_W-1:0]        w_rd_addr_inc;
  logic [1:0]               w_full_next;

  // Write strobe and overflow are combinational; reset gates them so they read 0 in reset.
  assign w_wr_full     = r_full[r_wr_sel];
  assign w_we          = reset && wr_valid && !w_wr_full && !r_drop;
  assign w_wr_done     = w_we && wr_last;
  assign w_ovf         = reset && wr_valid && !r_drop && w_wr_full;
  assign w_rd_done     = (r_state == ST_STREAM) && r_tlast && tready;
  assign w_len_m1      = r_len[r_rd_sel] - ADDR_W'(1);
  assign w_rd_addr_inc = r_rd_addr + ADDR_W'(1);

  // Release and completion always hit different buffers, so both bits can update together.
  always_comb begin
    w_full_next = r_full;
    if (w_rd_done) begin
      w_full_next[r_rd_sel] = 1'b0;
    end
    if (w_wr_done) begin
      w_full_next[r_wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full     <= '0;
      r_len      <= '0;
      r_sof      <= '0;
      r_sof_pend <= 1'b0;
      r_drop     <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_full <= w_full_next;
      if (w_we) begin
        if (wr_last) begin
          r_len[r_wr_sel] <= r_wr_addr + ADDR_W'(1);
          r_sof[r_wr_sel] <= r_sof_pend;
          r_wr_sel        <= ~r_wr_sel;
          r_wr_addr       <= '0;
        end else begin
          r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
      end
      // A new frame start wins over consumption by the completing line.
      if (fs_in) begin
        r_sof_pend <= 1'b1;
      end else if (w_wr_done) begin
        r_sof_pend <= 1'b0;
      end
      if (wr_valid && (r_drop || w_wr_full)) begin
        r_drop <= !wr_last;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_rd_sel  <= 1'b0;
      r_rd_addr <= '0;
      r_tvalid  <= 1'b0;
      r_tuser   <= 1'b0;
      r_tlast   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rd_sel]) begin
            r_state   <= ST_STREAM;
            r_rd_addr <= '0;
            r_tvalid  <= 1'b1;
            r_tuser   <= r_sof[r_rd_sel];
            r_tlast   <= (r_len[r_rd_sel] == ADDR_W'(1));
          end
        end
        ST_STREAM: begin
          if (tready) begin
            if (r_tlast) begin
              r_state   <= ST_IDLE;
              r_rd_sel  <= ~r_rd_sel;
              r_rd_addr <= '0;
              r_tvalid  <= 1'b0;
              r_tuser   <= 1'b0;
              r_tlast   <= 1'b0;
            end else begin
              r_rd_addr <= w_rd_addr_inc;
              r_tuser   <= 1'b0;
              r_tlast   <= (w_rd_addr_inc == w_len_m1);
            end
          end
        end
      endcase
    end
  end

  assign we      = w_we;
  assign ovf     = w_ovf;
  assign wr_sel  = r_wr_sel;
  assign wr_addr = r_wr_addr;
  assign rd_sel  = r_rd_sel;
  assign rd_addr = r_rd_addr;
  assign tvalid  = r_tvalid;
  assign tuser   = r_tuser;
  assign tlast   = r_tlast;
  assign full    = r_full;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Scoreboard bench for line_buf_ctrl: stimulus pushes expected stream beats,
// a monitor pops and compares them on every tvalid/tready handshake.
module tb_line_buf_ctrl;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              fs_in;
  logic              wr_valid;
  logic              wr_last;
  logic              tready;
  logic              we;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic              tvalid;
  logic              tuser;
  logic              tlast;
  logic              ovf;
  logic [1:0]        full;
  logic [31:0]       wr_data;

  line_buf_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .fs_in(fs_in), .wr_valid(wr_valid),
    .wr_last(wr_last), .tready(tready), .we(we), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .rd_sel(rd_sel), .rd_addr(rd_addr), .tvalid(tvalid),
    .tuser(tuser), .tlast(tlast), .ovf(ovf), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic              user;
    logic              last;
    logic [31:0]       data;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] tb_mem [2][16];
  int          n_cmp = 0;
  int          n_bad = 0;

  // tready source: 0 = always 1, 1 = toggling, 2 = always 0, 3 = manual
  int   tr_mode = 3;
  logic tog = 1'b0;
  logic tr_man = 1'b0;
  always @(negedge clk) tog <= ~tog;
  assign tready = (tr_mode == 0) ? 1'b1 :
                  (tr_mode == 1) ? tog  :
                  (tr_mode == 2) ? 1'b0 : tr_man;

  // Models the external line-buffer RAM
  always @(posedge clk) begin
    if (we) tb_mem[wr_sel][wr_addr[3:0]] <= wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t got;
    beat_t expv;
    #2;
    if (reset && tvalid && tready) begin
      got = {rd_sel, rd_addr, tuser, tlast, tb_mem[rd_sel][rd_addr[3:0]]};
      $display("beat sel=%0d addr=%0d user=%0d last=%0d data=%0h",
               rd_sel, rd_addr, tuser, tlast, got.data);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat: got unexpected beat %0h expected none", got);
      end else begin
        expv = sb.pop_front();
        chk("beat", 64'(got), 64'(expv));
      end
    end
  end

  task automatic send_line(input logic [31:0] base, input int n, input logic acc,
                           input logic exp_buf, input logic exp_sof, input logic ready_on_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_last  = (i == n - 1);
      wr_data  = base - 32'(i);
      if (ready_on_last && i == n - 1) tr_man = 1'b1;
      #1;
      chk("we", 64'(we), 64'(acc));
      chk("ovf", 64'(ovf), 64'(!acc && i == 0));
      if (acc) begin
        chk("wr_sel", 64'(wr_sel), 64'(exp_buf));
        chk("wr_addr", 64'(wr_addr), 64'(i));
        sb.push_back({exp_buf, ADDR_W'(i), logic'(exp_sof && i == 0),
                      logic'(i == n - 1), base - 32'(i)});
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (ready_on_last) tr_man = 1'b0;
    #1;
    $display("line base=%0h words=%0d accepted=%0d", base, n, acc);
  endtask

  task automatic frame_start();
    @(negedge clk);
    fs_in = 1'b1;
    @(negedge clk);
    fs_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && full == 2'b00 && !tvalid) break;
    end
    n_cmp++;
    if (k == 300) begin
      n_bad++;
      $display("FAIL %s: got timeout with %0d beats left full=%b expected drained", name, sb.size(), full);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, 64'(we), 0);
    chk({tag, "_tvalid"}, 64'(tvalid), 0);
    chk({tag, "_tuser"}, 64'(tuser), 0);
    chk({tag, "_tlast"}, 64'(tlast), 0);
    chk({tag, "_ovf"}, 64'(ovf), 0);
    chk({tag, "_full"}, 64'(full), 0);
    chk({tag, "_wr_sel"}, 64'(wr_sel), 0);
    chk({tag, "_rd_sel"}, 64'(rd_sel), 0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; fs_in = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
    #3 reset = 1'b0;
    wr_valid = 1'b1;
    #1 chk_reset("rst");
    repeat (2) @(negedge clk);
    wr_valid = 1'b0;
    reset = 1'b1;

    // Single line with frame start
    tr_mode = 0;
    frame_start();
    send_line(32'h05, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("single_full", 64'(full), 64'(2'b01));
    chk("single_idle_gap", 64'(tvalid), 0);
    @(negedge clk); #1;
    chk("single_tvalid", 64'(tvalid), 1);
    chk("single_tuser", 64'(tuser), 1);
    wait_idle("single");
    chk("single_full_end", 64'(full), 0);

    // Backpressure with toggling tready, second buffer
    tr_mode = 1;
    send_line(32'h25, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle("backpressure");

    // Ping-pong then overflow with sink stalled
    tr_mode = 2;
    frame_start();
    send_line(32'h45, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    send_line(32'h65, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pingpong_full", 64'(full), 64'(2'b11));
    send_line(32'h85, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_full", 64'(full), 64'(2'b11));
    tr_mode = 0;
    wait_idle("pingpong");

    // Completion into buffer 1 coincides with buffer 0 tlast handshake
    tr_mode = 3;
    tr_man = 1'b0;
    send_line(32'hA1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(32'hC5, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("simul_full", 64'(full), 64'(2'b10));
    chk("simul_rd_sel", 64'(rd_sel), 1);
    chk("simul_idle_gap", 64'(tvalid), 0);
    @(negedge clk); #1;
    chk("simul_tvalid", 64'(tvalid), 1);
    tr_mode = 0;
    wait_idle("simul");

    // Reset in the middle of a stream
    tr_mode = 3;
    tr_man = 1'b0;
    send_line(32'hE5, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_start();
    tr_man = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tvalid && rd_addr == ADDR_W'(2)) break;
    end
    n_cmp++;
    if (k == 50) begin
      n_bad++;
      $display("FAIL midreset_wait: got rd_addr %0d expected 2", rd_addr);
    end
    reset = 1'b0;
    wr_valid = 1'b1;
    #1 chk_reset("midrst");
    sb.delete();
    repeat (2) @(negedge clk);
    wr_valid = 1'b0;
    tr_man = 1'b0;
    reset = 1'b1;
    tr_mode = 0;
    send_line(32'hF5, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle("after_reset");
    chk("final_full", 64'(full), 0);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d beats expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
